// File: rtl/hex_disp_pkg.sv
// Shared constants, types and segment helpers for the hex score display.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hex_disp_pkg;

    localparam int BIN_W      = 16;  // score width fed to the BCD engine
    localparam int BCD_W      = 20;  // five packed BCD digits
    localparam int BCD_DIGITS = 5;

    // Posture state codes as carried in the status word bits [19:16]
    localparam logic [3:0] SC_DASH = 4'd0;
    localparam logic [3:0] SC_G    = 4'd1;
    localparam logic [3:0] SC_B    = 4'd2;
    localparam logic [3:0] SC_C    = 4'd3;

    // Active-high segment bytes, bit0=a .. bit6=g, bit7 unused
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_G     = 8'h3D;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_E     = 8'h79;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } disp_state_e;

    // Decimal digit to segment byte; non-decimal codes render blank
    function automatic logic [7:0] seg7_digit(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // State code to HEX5 glyph; every unknown code shows 'E'
    function automatic logic [7:0] state_glyph(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            SC_DASH: seg = SEG_DASH;
            SC_G:    seg = SEG_G;
            SC_B:    seg = SEG_B;
            SC_C:    seg = SEG_C;
            default: seg = SEG_E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: 16-bit binary to 5-digit BCD, one bit per clock.
// Latency: 16 cycles after the start edge; result_o valid from the cycle after done_o.
// Backpressure: start_i is ignored while a conversion is running.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   start_i        load bin_i and begin converting (sampled only when idle)
//   bin_i          binary value to convert
//   done_o         high in the cycle whose closing edge performs the final shift
//   bcd_o          BCD result {d4,d3,d2,d1,d0}
module bin2bcd_serial
    import hex_disp_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    // {BCD digits, remaining binary bits}
    logic [BCD_W+BIN_W-1:0] sr_q;
    logic [BCD_W+BIN_W-1:0] adj;
    logic [3:0]             cnt_q;
    logic                   run_q;

    // Add 3 to every BCD nibble >= 5 so the following shift carries correctly
    always_comb begin
        adj = sr_q;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (sr_q[BIN_W+4*k +: 4] >= 4'd5) begin
                adj[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (run_q) begin
            sr_q  <= {adj[BCD_W+BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_q <= 1'b0;
            end
        end else if (start_i) begin
            sr_q  <= {{BCD_W{1'b0}}, bin_i};
            cnt_q <= '0;
            run_q <= 1'b1;
        end
    end

    assign done_o = run_q && (cnt_q == 4'd15);
    assign bcd_o  = sr_q[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/hex_score_display.sv
// Seven-segment front end: score -> BCD digits on HEX0..HEX4, posture glyph on HEX5, alert blink.
// Latency: 18 cycles from q_in change to visible digits; alert blanking follows q_in[31] after 1 cycle.
// Backpressure: none; changes during a conversion are held and only the newest word is converted next.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   q_in           status word: [15:0] score, [19:16] state code, [31] alert
//   hex3_hex0      {HEX3,HEX2,HEX1,HEX0} active-high segment bytes
//   hex5_hex4      {HEX5,HEX4} active-high segment bytes
//   busy           high while a conversion is in flight
// Build option: define HEX_LZ_BLANK_EN to blank leading-zero digits.
module hex_score_display
    import hex_disp_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] q_in,
    output logic [31:0] hex3_hex0,
    output logic [15:0] hex5_hex4,
    output logic        busy
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [31:0]            q_r;
    logic [19:0]            last_r;
    disp_state_e            state_q;
    logic [BCD_W-1:0]       disp_bcd_q;
    logic [3:0]             disp_code_q;
    logic                   disp_vld_q;  // stays low until the first commit after reset
    logic [CNT_W-1:0]       blink_cnt_q;
    logic                   phase_on_q;

    logic                   conv_start;
    logic                   conv_done;
    logic [BCD_W-1:0]       conv_bcd;
    logic                   blank_digits;
    logic [4:0][7:0]        digit_seg;
    logic [7:0]             glyph;
`ifdef HEX_LZ_BLANK_EN
    logic                   seen_nz;
`endif

    // Bits [30:20] of the status word carry nothing for this block
    logic unused_q_bits;
    assign unused_q_bits = ^q_r[30:20];

    // Same-domain PIO register, a plain capture stage is enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else begin
            q_r <= q_in;
        end
    end

    // Alert is deliberately excluded from change detection
    assign conv_start = (state_q == ST_IDLE) && (q_r[19:0] != last_r);

    bin2bcd_serial u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (conv_start),
        .bin_i   (q_r[15:0]),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_r      <= '0;
            disp_bcd_q  <= '0;
            disp_code_q <= '0;
            disp_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (conv_start) begin
                        last_r  <= q_r[19:0];
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (conv_done) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // State code comes from the accepted word, not the live one
                    disp_bcd_q  <= conv_bcd;
                    disp_code_q <= last_r[19:16];
                    disp_vld_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

    // Free-running blink timebase; runs regardless of alert
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_on_q  <= ~phase_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        digit_seg    = '0;
        blank_digits = !disp_vld_q || (q_r[31] && !phase_on_q);
`ifdef HEX_LZ_BLANK_EN
        seen_nz      = 1'b0;
`endif
        // Walk from the most significant digit so leading zeros can be tracked
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            digit_seg[i] = seg7_digit(disp_bcd_q[4*i +: 4]);
`ifdef HEX_LZ_BLANK_EN
            seen_nz = seen_nz || (disp_bcd_q[4*i +: 4] != 4'd0);
            if (!seen_nz && (i != 0)) begin
                digit_seg[i] = SEG_BLANK;
            end
`endif
            if (blank_digits) begin
                digit_seg[i] = SEG_BLANK;
            end
        end
        glyph = disp_vld_q ? state_glyph(disp_code_q) : SEG_BLANK;
    end

    assign hex3_hex0 = digit_seg[3:0];
    assign hex5_hex4 = {glyph, digit_seg[4]};

endmodule

// File: tb/tb_hex_score_display.sv
module tb_hex_score_display;

    localparam int BD = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] q_in;
    logic [31:0] hex3_hex0;
    logic [15:0] hex5_hex4;
    logic        busy;

    int          checks;
    int          errors;
    int unsigned cyc;

    // Reference model: what the display should currently hold
    logic [15:0] m_score;
    logic [3:0]  m_state;
    logic        m_vld;

    int         pow10   [5]  = '{1, 10, 100, 1000, 10000};
    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    hex_score_display #(.BLINK_DIV(BD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q_in      (q_in),
        .hex3_hex0 (hex3_hex0),
        .hex5_hex4 (hex5_hex4),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; drives the blink phase prediction
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [47:0] model_out();
        logic [7:0] seg [5];
        logic [7:0] glyph;
        logic       dark;
        if (!m_vld) return 48'h0;
        dark = q_in[31] && (((cyc / BD) % 2) == 1);
        for (int i = 0; i < 5; i++) begin
            seg[i] = seg_tab[(int'(m_score) / pow10[i]) % 10];
`ifdef HEX_LZ_BLANK_EN
            if (i > 0 && int'(m_score) < pow10[i]) seg[i] = 8'h00;
`endif
            if (dark) seg[i] = 8'h00;
        end
        case (m_state)
            4'd0:    glyph = 8'h40;
            4'd1:    glyph = 8'h3D;
            4'd2:    glyph = 8'h7C;
            4'd3:    glyph = 8'h39;
            default: glyph = 8'h79;
        endcase
        return {glyph, seg[4], seg[3], seg[2], seg[1], seg[0]};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a word that differs in [19:0] from the displayed one and follow it to commit
    task automatic apply(input logic [31:0] w, input string tag);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        q_in = w;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k == 17) begin
                check({tag, "_pre"}, {hex5_hex4, hex3_hex0}, model_out());
                m_score = w[15:0];
                m_state = w[19:16];
                m_vld   = 1'b1;
            end
            if (k == 18) check(tag, {hex5_hex4, hex3_hex0}, model_out());
        end
        check({tag, "_busy"}, 48'(busy_cnt), 48'd17);
    endtask

    initial begin
        logic [31:0] w;
        logic [47:0] prev;
        logic [47:0] cur;
        logic [47:0] v1;
        logic [47:0] v2;
        logic [47:0] e1;
        logic [47:0] e2;
        int          changes;
        int          t1;
        int          t2;
        int          nblank;
        int          nshow;

        checks  = 0;
        errors  = 0;
        m_score = '0;
        m_state = '0;
        m_vld   = 1'b0;
        q_in    = '0;
        reset_n = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_hex", {hex5_hex4, hex3_hex0}, 48'h0);
        check("reset_busy", 48'(busy), 48'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_blank", {hex5_hex4, hex3_hex0}, model_out());
        check("idle_busy", 48'(busy), 48'd0);

        apply(32'h0001_3039, "s12345");
        check("s12345_const", {hex5_hex4, hex3_hex0}, 48'h3D06_5B4F666D);

        apply(32'h0002_FFFF, "s65535");
        check("s65535_const", {hex5_hex4, hex3_hex0}, 48'h7C7D_6D6D4F6D);

        apply(32'h0000_002A, "s42");
`ifdef HEX_LZ_BLANK_EN
        check("s42_const", {hex5_hex4, hex3_hex0}, 48'h4000_0000665B);
`else
        check("s42_const", {hex5_hex4, hex3_hex0}, 48'h403F_3F3F665B);
`endif

        apply(32'h0003_0000, "s0");

        // Pending update: 100, then 200 arriving mid-conversion
        @(negedge clk);
        q_in    = 32'd100;
        prev    = {hex5_hex4, hex3_hex0};
        changes = 0;
        t1 = -1; t2 = -1; v1 = '0; v2 = '0;
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            cur = {hex5_hex4, hex3_hex0};
            if (cur !== prev) begin
                changes++;
                if (changes == 1) begin t1 = k; v1 = cur; end
                if (changes == 2) begin t2 = k; v2 = cur; end
            end
            prev = cur;
            if (k == 5) q_in = 32'd200;
        end
        m_vld = 1'b1; m_state = 4'd0;
        m_score = 16'd100; e1 = model_out();
        m_score = 16'd200; e2 = model_out();
        check("pend_changes", 48'(changes), 48'd2);
        check("pend_t1", 48'(t1), 48'd18);
        check("pend_v1", v1, e1);
        check("pend_t2", 48'(t2), 48'd36);
        check("pend_v2", v2, e2);

        // Random words, alert included
        for (int n = 0; n < 10; n++) begin
            w = $urandom();
            while (w[19:0] == {m_state, m_score}) w = $urandom();
            apply(w, "rand");
        end

        // Alert blink
        apply(32'h8001_3039, "alert");
        nblank = 0;
        nshow  = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("blink", {hex5_hex4, hex3_hex0}, model_out());
            check("blink_hex5", 48'(hex5_hex4[15:8]), 48'h3D);
            if (hex3_hex0 == 32'h0) nblank++;
            else                    nshow++;
        end
        check("blink_alt", 48'((nblank > 0) && (nshow > 0)), 48'd1);
        @(negedge clk);
        q_in = 32'h0001_3039;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("unblink", {hex5_hex4, hex3_hex0}, 48'h3D06_5B4F666D);
        end

        // Reset in the middle of a conversion
        @(negedge clk);
        q_in = 32'h0003_0457;
        for (int k = 0; k <= 10; k++) @(negedge clk);
        reset_n = 1'b0;
        m_vld   = 1'b0;
        #1;
        check("midrst_hex", {hex5_hex4, hex3_hex0}, 48'h0);
        check("midrst_busy", 48'(busy), 48'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 18) begin
                check("postrst_pre", {hex5_hex4, hex3_hex0}, model_out());
                m_score = 16'h0457;
                m_state = 4'd3;
                m_vld   = 1'b1;
            end
            if (k == 19) check("postrst", {hex5_hex4, hex3_hex0}, model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
